fifo_flex: RTL
==============

Name: fifo_flex

Overview:
- Parametrised synchronous FIFO, the successor to the fixed 8x8 FIFO.
- Generalised WIDTH/DEPTH, with occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable output mode (show-ahead or registered read).
- Sits between producer/consumer blocks in the same clock domain; used as the standard buffering primitive.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- PTRWID, $clog2(DEPTH)+1, pointer/count width; derived, not to be overridden.
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1).
- OUT_REG, 0, 0 = show-ahead (data_out = head entry, combinational from storage); 1 = registered read (data_out loaded on accepted pop).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- push  input  1  write request.
- pop  input  1  read request.
- data_in  input  WIDTH  write data.
- err_clr  input  1  synchronous clear of sticky error flags.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  PTRWID  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: push seen while full.
- underflow  output  1  sticky: pop seen while empty.
- data_out  output  WIDTH  read data (see OUT_REG).

Behaviour:
- Reset (async assert, sync-safe release):
  - wrPtr = rdPtr = 0; count 0; empty 1, full 0, almost_empty 1, almost_full 0 (unless AF_THRESH==0, disallowed).
  - overflow = underflow = 0; data_out = 0; all storage entries = 0.
- Pointers are PTRWID bits; the low PTRWID-1 bits index storage and the MSB is the wrap bit.
  - empty = (wrPtr == rdPtr).
  - full = low bits equal and MSBs differ.
  - count = wrPtr - rdPtr modulo 2^PTRWID.
  - All flags are derived combinationally from the registered pointers, so they update the cycle after the accepted operation.
- Acceptance: push_ok = push & ~full; pop_ok = pop & ~empty, both evaluated on pre-edge state.
  - push_ok: entry[wrPtr low] <= data_in; wrPtr += 1.
  - pop_ok: rdPtr += 1.
  - Simultaneous push_ok & pop_ok: both occur; count unchanged. This covers push+pop when neither full nor empty.
  - Push while full is rejected even when pop is asserted in the same cycle: the pop is accepted, the push is dropped, and overflow is set. This is decided; producers must honour full.
  - Pop while empty is rejected even with a simultaneous push: the push is accepted, the pop is dropped, and underflow is set.
- Errors:
  - overflow <= 1 on push & full; underflow <= 1 on pop & empty.
  - err_clr clears both; a new error in the same cycle as err_clr wins (flag stays 1).
- OUT_REG=0: data_out = entry[rdPtr low] continuously. When empty, it shows stale or zero storage, which is don't-care for consumers.
- OUT_REG=1:
  - On pop_ok, data_out <= entry[rdPtr low] (pre-increment), giving 1-cycle read latency.
  - data_out otherwise holds; a rejected pop does not change it.
- Pointer wrap: the low bits roll over at DEPTH; the MSB toggles. There is no special case at the wrap boundary.
- Rejected operations never modify storage or pointers.

Decomposition:
- Package fifo_pkg: function ptr_width(depth) = $clog2(depth)+1; localparam constants OUT_SHOWAHEAD=0 and OUT_REGISTERED=1.
- Sub-module fifo_ptr (PTRWID): one wrap-bit pointer with async reset and an increment enable; instantiated twice, for wrPtr and rdPtr.
- Storage, flag logic and the output register stay in fifo_flex.

Test Plan:
- Reset mid-stream: DEPTH=8, push 5 words, assert rst asynchronously between edges → count 0, empty 1, data_out 0 immediately, before the next edge.
- Fill/drain with wrap: DEPTH=8, push 0x01..0x0C interleaved so pointers wrap past 8 → pops return the values in order; full 1 exactly at count 8; count never exceeds 8.
- Overflow: fill to 8, push 0xAA with pop 1 → count 7, head popped, 0xAA not stored, overflow 1; err_clr for one cycle → overflow 0.
- Underflow + push: empty, pop 1 and push 0x33 in the same cycle → count 1, underflow 1; OUT_REG=1: data_out unchanged (0).
- Thresholds: AF_THRESH=6, AE_THRESH=2; push 6 words → almost_empty deasserts at count 3, almost_full asserts at count 6; pop 4 → almost_full deasserts at count 5, almost_empty reasserts at count 2.
- Registered mode: OUT_REG=1, push 0x11 then 0x22, then pop on two consecutive cycles → data_out 0x11 one cycle after the first pop, 0x22 after the second; it holds 0x22 while pop is low.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared helpers and output-mode constants for fifo_flex
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int OUT_SHOWAHEAD  = 0;
    localparam int OUT_REGISTERED = 1;

    // One extra bit beyond the storage index serves as the wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_ptr.sv
// ============================================================================
// fifo_ptr : wrap-bit FIFO pointer with asynchronous reset and increment enable
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module fifo_ptr #(
    parameter int PTRWID = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [PTRWID-1:0] ptr
);

    localparam logic [PTRWID-1:0] c_one = {{(PTRWID-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + c_one;
        end
    end

endmodule : fifo_ptr

`default_nettype wire

// File: rtl/fifo_flex.sv
// ============================================================================
// fifo_flex : parametrised synchronous FIFO with count, threshold flags,
//             sticky error flags and show-ahead / registered output modes
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module fifo_flex
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int PTRWID    = ptr_width(DEPTH),
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int OUT_REG   = OUT_SHOWAHEAD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              err_clr,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [PTRWID-1:0] count,
    output logic              overflow,
    output logic              underflow,
    output logic [WIDTH-1:0]  data_out
);

    localparam int                c_aw        = PTRWID - 1;
    localparam logic [PTRWID-1:0] c_af_thresh = PTRWID'(AF_THRESH);
    localparam logic [PTRWID-1:0] c_ae_thresh = PTRWID'(AE_THRESH);

    logic [PTRWID-1:0] w_wr_ptr;
    logic [PTRWID-1:0] w_rd_ptr;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              r_overflow;
    logic              r_underflow;

    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop  & ~empty;

    fifo_ptr #(.PTRWID(PTRWID)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_push_ok),
        .ptr (w_wr_ptr)
    );

    fifo_ptr #(.PTRWID(PTRWID)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_pop_ok),
        .ptr (w_rd_ptr)
    );

    // Flags come straight from the registered pointers, one cycle after the op.
    assign count        = w_wr_ptr - w_rd_ptr;
    assign empty        = (w_wr_ptr == w_rd_ptr);
    assign full         = (w_wr_ptr[c_aw-1:0] == w_rd_ptr[c_aw-1:0]) &&
                          (w_wr_ptr[c_aw] != w_rd_ptr[c_aw]);
    assign almost_full  = (count >= c_af_thresh);
    assign almost_empty = (count <= c_ae_thresh);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[w_wr_ptr[c_aw-1:0]] <= data_in;
        end
    end

    // A fresh error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (pop && empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (OUT_REG == OUT_REGISTERED) begin : g_registered
            logic [WIDTH-1:0] r_data_out;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data_out <= '0;
                end else if (w_pop_ok) begin
                    r_data_out <= r_mem[w_rd_ptr[c_aw-1:0]];
                end
            end

            assign data_out = r_data_out;
        end else begin : g_showahead
            assign data_out = r_mem[w_rd_ptr[c_aw-1:0]];
        end
    endgenerate

endmodule : fifo_flex

`default_nettype wire
